// File: rtl/outpkt_builder.sv
// Frames one arbiter item (RESULT / CMP_RESULT / PACKET_DONE) into a 16-bit word stream.
// Optional trailing checksum word when OUTPKT_CHECKSUM_EN is defined.
module outpkt_builder #(
  parameter int PKT_NUM_WORDS = 12,
  parameter int VERSION       = 2,
  parameter int TYPE_W        = 2,
  parameter int HASH_W        = 8,
  parameter int ADDR_W        = $clog2(PKT_NUM_WORDS)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              src_empty,
  input  logic [TYPE_W-1:0] outpkt_type,
  input  logic [15:0]       src_din,
  output logic [ADDR_W-1:0] src_rd_addr,
  input  logic [15:0]       pkt_id,
  input  logic [31:0]       num_processed,
  input  logic [HASH_W-1:0] hash_num,
  output logic              src_rd_en,
  output logic [15:0]       dout,
  output logic              wr_en,
  input  logic              full,
  output logic              err
);
  localparam logic [TYPE_W-1:0] T_RESULT      = TYPE_W'(1);
  localparam logic [TYPE_W-1:0] T_CMP_RESULT  = TYPE_W'(2);
  localparam logic [TYPE_W-1:0] T_PACKET_DONE = TYPE_W'(3);
  localparam int CNT_W = $clog2(PKT_NUM_WORDS + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR0, S_HDR1, S_HDR2, S_BODY,
`ifdef OUTPKT_CHECKSUM_EN
    S_CSUM,
`endif
    S_ACK
  } state_t;

  state_t            state_q, state_d;
  logic [TYPE_W-1:0] typ_q;
  logic [15:0]       id_q;
  logic [31:0]       np_q;
  logic [HASH_W-1:0] hash_q;
  logic [CNT_W-1:0]  idx_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              err_q;
  logic              in_known, word_vld, last_word, buf_word;
  logic [15:0]       pay_len, body_word;

  assign in_known = (outpkt_type == T_RESULT) || (outpkt_type == T_CMP_RESULT) ||
                    (outpkt_type == T_PACKET_DONE);

  always_comb begin
    pay_len   = 16'd0;
    body_word = 16'd0;
    buf_word  = 1'b0;
    case (typ_q)
      T_RESULT: begin
        pay_len   = 16'(PKT_NUM_WORDS);
        body_word = src_din;
        buf_word  = 1'b1;
      end
      T_CMP_RESULT: begin
        // hash index leads, buffer words follow
        pay_len   = 16'(PKT_NUM_WORDS + 1);
        body_word = (idx_q == '0) ? 16'(hash_q) : src_din;
        buf_word  = (idx_q != '0);
      end
      T_PACKET_DONE: begin
        pay_len   = 16'd2;
        body_word = (idx_q == '0) ? np_q[15:0] : np_q[31:16];
      end
      default: ;
    endcase
  end

  assign last_word = (16'(idx_q) == pay_len - 16'd1);

`ifdef OUTPKT_CHECKSUM_EN
  logic [15:0] csum_q;
`endif

  // state register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next state: every word-emitting state advances only on a transferred word
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!src_empty) state_d = in_known ? S_HDR0 : S_ACK;
      S_HDR0: if (wr_en) state_d = S_HDR1;
      S_HDR1: if (wr_en) state_d = S_HDR2;
      S_HDR2: if (wr_en) state_d = S_BODY;
`ifdef OUTPKT_CHECKSUM_EN
      S_BODY: if (wr_en && last_word) state_d = S_CSUM;
      S_CSUM: if (wr_en) state_d = S_ACK;
`else
      S_BODY: if (wr_en && last_word) state_d = S_ACK;
`endif
      S_ACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    word_vld  = 1'b0;
    dout      = 16'd0;
    src_rd_en = 1'b0;
    case (state_q)
      S_HDR0: begin word_vld = 1'b1; dout = {8'(VERSION), 8'(typ_q)}; end
      S_HDR1: begin word_vld = 1'b1; dout = id_q; end
      S_HDR2: begin word_vld = 1'b1; dout = pay_len; end
      S_BODY: begin word_vld = 1'b1; dout = body_word; end
`ifdef OUTPKT_CHECKSUM_EN
      S_CSUM: begin word_vld = 1'b1; dout = ~csum_q; end
`endif
      S_ACK:  src_rd_en = 1'b1;
      default: ;
    endcase
  end

  assign wr_en       = word_vld & ~full;
  assign src_rd_addr = rd_addr_q;
  assign err         = err_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      typ_q     <= '0;
      id_q      <= '0;
      np_q      <= '0;
      hash_q    <= '0;
      idx_q     <= '0;
      rd_addr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == S_IDLE && !src_empty) begin
        typ_q  <= outpkt_type;
        id_q   <= pkt_id;
        np_q   <= num_processed;
        hash_q <= hash_num;
        idx_q  <= '0;
        if (!in_known) err_q <= 1'b1;
      end
      if (state_q == S_BODY && wr_en) begin
        idx_q <= last_word ? '0 : idx_q + CNT_W'(1);
        if (buf_word)
          rd_addr_q <= (rd_addr_q == ADDR_W'(PKT_NUM_WORDS - 1)) ? '0 : rd_addr_q + ADDR_W'(1);
      end
    end
  end

`ifdef OUTPKT_CHECKSUM_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)                                    csum_q <= '0;
    else if (state_q == S_IDLE && !src_empty)     csum_q <= '0;
    else if (wr_en && state_q != S_CSUM)          csum_q <= csum_q + dout;
  end
`endif

endmodule

// File: tb/tb_outpkt_builder.sv
// Bench for outpkt_builder: arbiter model plus a frame-level reference built from the item fields.
module tb_outpkt_builder;
  localparam int N = 12;
  localparam logic [1:0] RES = 2'd1, CMP = 2'd2, PD = 2'd3, BAD = 2'd0;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        src_empty;
  logic [1:0]  outpkt_type;
  logic [15:0] src_din;
  logic [3:0]  src_rd_addr;
  logic [15:0] pkt_id;
  logic [31:0] num_processed;
  logic [7:0]  hash_num;
  logic        src_rd_en;
  logic [15:0] dout;
  logic        wr_en;
  logic        full;
  logic        err;

  logic [15:0] buf_mem [16];
  logic        item_pending;
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  assign src_empty = ~item_pending;
  assign src_din   = buf_mem[src_rd_addr];

  outpkt_builder dut (
    .CLK(CLK), .RESET(RESET), .src_empty(src_empty), .outpkt_type(outpkt_type),
    .src_din(src_din), .src_rd_addr(src_rd_addr), .pkt_id(pkt_id),
    .num_processed(num_processed), .hash_num(hash_num), .src_rd_en(src_rd_en),
    .dout(dout), .wr_en(wr_en), .full(full), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: header, payload from the item's fields, optional inverted sum.
  task automatic build_exp();
    logic [15:0] sum;
    exp_q.delete();
    if (outpkt_type == BAD) return;
    exp_q.push_back({8'd2, 6'd0, outpkt_type});
    exp_q.push_back(pkt_id);
    case (outpkt_type)
      RES: exp_q.push_back(16'(N));
      CMP: exp_q.push_back(16'(N + 1));
      default: exp_q.push_back(16'd2);
    endcase
    if (outpkt_type == PD) begin
      exp_q.push_back(num_processed[15:0]);
      exp_q.push_back(num_processed[31:16]);
    end else begin
      if (outpkt_type == CMP) exp_q.push_back({8'd0, hash_num});
      for (int i = 0; i < N; i++) exp_q.push_back(buf_mem[i]);
    end
`ifdef OUTPKT_CHECKSUM_EN
    sum = 16'd0;
    foreach (exp_q[i]) sum = sum + exp_q[i];
    exp_q.push_back(~sum);
`endif
  endtask

  task automatic load_item(input logic [1:0] t, input logic [15:0] id, input logic [31:0] np,
                           input logic [7:0] h, input int buf_kind);
    outpkt_type = t; pkt_id = id; num_processed = np; hash_num = h;
    for (int i = 0; i < 16; i++)
      buf_mem[i] = (buf_kind == 0) ? 16'(16'h1000 + i) : 16'($urandom);
    build_exp();
    item_pending = 1'b1;
  endtask

  // Drives full per mode (0 off, 1 toggle, 2 random), collects words until the ack plus a tail.
  task automatic run_item(input string name, input int mode, input logic exp_err);
    int acks = 0, last_wr = -1, ack_cyc = -1, full_viol = 0, post = 0;
    logic acked;
    got_q.delete();
    for (int cyc = 0; cyc < 400 && post < 4; cyc++) begin
      case (mode)
        0: full = 1'b0;
        1: full = (cyc % 2) == 1;
        default: full = ($urandom_range(0, 2) == 0);
      endcase
      #1;
      if (wr_en && full) full_viol++;
      if (wr_en) begin got_q.push_back(dout); last_wr = cyc; end
      acked = src_rd_en;
      if (src_rd_en) begin acks++; ack_cyc = cyc; end
      // scramble inputs while busy; the latched copy must be used
      if (cyc == 2) begin pkt_id = ~pkt_id; num_processed = ~num_processed; hash_num = ~hash_num; end
      @(posedge CLK);
      @(negedge CLK);
      if (acked) item_pending = 1'b0;
      if (acks > 0) post++;
    end
    full = 1'b0;
    check({name, ".nwords"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s.w%0d", name, i), (i < got_q.size()) ? {16'd0, got_q[i]} : 32'hdead_beef,
            {16'd0, exp_q[i]});
    check({name, ".acks"}, acks, 1);
    check({name, ".wr_while_full"}, full_viol, 0);
    check({name, ".err"}, err, exp_err);
    if (exp_q.size() > 0) check({name, ".ack_lat"}, ack_cyc, last_wr + 1);
  endtask

  initial begin
    RESET = 1'b1; full = 1'b0; item_pending = 1'b0;
    outpkt_type = '0; pkt_id = '0; num_processed = '0; hash_num = '0;
    for (int i = 0; i < 16; i++) buf_mem[i] = '0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst.wr_en", wr_en, 0);
    check("rst.src_rd_en", src_rd_en, 0);
    check("rst.err", err, 0);
    check("rst.addr", src_rd_addr, 0);
    RESET = 1'b0;
    @(negedge CLK);

    load_item(RES, 16'h0042, 32'h0, 8'h0, 0);
    run_item("result", 0, 1'b0);
    load_item(RES, 16'h0043, 32'h0, 8'h0, 0);
    run_item("result_fulltog", 1, 1'b0);
    load_item(PD, 16'h00AB, 32'h12345678, 8'h0, 0);
    run_item("pkt_done", 0, 1'b0);
    load_item(CMP, 16'h0077, 32'h0, 8'd5, 1);
    run_item("cmp_result", 1, 1'b0);
    check("addr_idle", src_rd_addr, 0);

    for (int k = 0; k < 16; k++) begin
      load_item(2'($urandom_range(1, 3)), 16'($urandom), $urandom, 8'($urandom), 1);
      run_item($sformatf("rand%0d", k), $urandom_range(0, 2), 1'b0);
    end

    load_item(BAD, 16'h0011, 32'h0, 8'h0, 1);
    run_item("unknown", 0, 1'b1);
    load_item(PD, 16'h0012, 32'hCAFE_F00D, 8'h0, 1);
    run_item("after_unknown", 2, 1'b1);

    // Reset after the third word: frame truncated, no ack, item re-sent whole.
    begin
      int nw = 0, early_ack = 0;
      load_item(RES, 16'h0BAD, 32'h0, 8'h0, 1);
      for (int c = 0; c < 50 && nw < 3; c++) begin
        full = 1'b0;
        #1;
        if (wr_en) nw++;
        if (src_rd_en) early_ack++;
        @(posedge CLK);
        @(negedge CLK);
      end
      check("mid_rst.words_before", nw, 3);
      RESET = 1'b1;
      #1;
      check("mid_rst.wr_en", wr_en, 0);
      check("mid_rst.src_rd_en", src_rd_en, 0);
      check("mid_rst.addr", src_rd_addr, 0);
      check("mid_rst.err_clr", err, 0);
      repeat (2) begin
        @(negedge CLK);
        if (src_rd_en) early_ack++;
      end
      check("mid_rst.no_ack", early_ack, 0);
      RESET = 1'b0;
      run_item("resend", 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
